// File: rtl/code_seq_pkg.sv
// Shared definitions for the startup-code checker (and its generator counterpart).
package code_seq_pkg;

    localparam int unsigned CODE_W  = 8;
    localparam int unsigned SIG_LEN = 5;

    // Startup signature; the generator drives these same codes in this order.
    localparam logic [CODE_W-1:0] SIG_CODES [0:SIG_LEN-1] = '{
        8'h10, 8'h92, 8'h53, 8'hEE, 8'h77
    };

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StCheck    = 2'd1,
        StDoneOk   = 2'd2,
        StDoneFail = 2'd3
    } state_e;

    // Expected code at a given progress index; out-of-range indices return 0.
    function automatic logic [CODE_W-1:0] sig_code(input logic [2:0] idx);
        if (32'(idx) < SIG_LEN) begin
            return SIG_CODES[idx];
        end
        return '0;
    endfunction

endpackage

// File: rtl/seq_timeout.sv
// Loadable down-counter: counts down while enabled, flags expiry at zero.
module seq_timeout #(
    parameter int unsigned TO_W = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_clr,
    input  logic            i_load,
    input  logic [TO_W-1:0] i_load_val,
    input  logic            i_dec,
    output logic            o_expire
);

    logic [TO_W-1:0] r_count;

    // Clear has priority over load; decrement stops at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_expire = (r_count == '0);

endmodule

// File: rtl/code_seq_checker.sv
// Checks an incoming code stream against the fixed startup signature.
module code_seq_checker #(
    parameter int unsigned CODE_W    = 8,
    parameter int unsigned SEQ_LEN   = 5,
    parameter int unsigned TO_W      = 16,
    parameter int unsigned TO_CYCLES = 1000,
    parameter int unsigned ERR_W     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CODE_W-1:0] i_code_in,
    input  logic              i_code_valid,
    input  logic              i_rearm,
    output logic [CODE_W-1:0] o_led,
    output logic              o_busy,
    output logic              o_seq_ok,
    output logic              o_seq_fail,
    output logic [CODE_W-1:0] o_fail_code,
    output logic [2:0]        o_match_idx,
    output logic [ERR_W-1:0]  o_err_count
);

    import code_seq_pkg::*;

    if (CODE_W != code_seq_pkg::CODE_W) begin : g_bad_code_w
        $error("CODE_W must match the package code width");
    end
    if (SEQ_LEN != SIG_LEN || SEQ_LEN > 7) begin : g_bad_seq_len
        $error("SEQ_LEN must match the signature length");
    end
    if (TO_CYCLES < 2 || 64'(TO_CYCLES) > ((64'd1 << TO_W) - 64'd1)) begin : g_bad_to
        $error("TO_CYCLES must be in [2, 2^TO_W-1]");
    end

    localparam logic [2:0]      LastIdx = 3'(SEQ_LEN);
    localparam logic [TO_W-1:0] ToLoad  = TO_W'(TO_CYCLES - 1);

    state_e            r_state, w_state_nxt;
    logic [CODE_W-1:0] r_led, w_led_nxt;
    logic [CODE_W-1:0] r_fail_code, w_fail_code_nxt;
    logic [2:0]        r_match_idx, w_match_idx_nxt;
    logic [ERR_W-1:0]  r_err_count;
    logic              r_seq_ok, w_seq_ok_nxt;
    logic              r_seq_fail, w_seq_fail_nxt;
    logic              w_err_inc;
    logic              w_to_clr, w_to_load, w_to_dec, w_to_expire;
    logic              w_hit;

    seq_timeout #(
        .TO_W (TO_W)
    ) u_timeout (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clr      (w_to_clr),
        .i_load     (w_to_load),
        .i_load_val (ToLoad),
        .i_dec      (w_to_dec),
        .o_expire   (w_to_expire)
    );

    // match_idx is 0 in IDLE, so this covers the first code as well.
    assign w_hit = i_code_valid && (i_code_in == sig_code(r_match_idx));

    // Next-state and register updates for the checker FSM.
    always_comb begin
        w_state_nxt     = r_state;
        w_led_nxt       = r_led;
        w_fail_code_nxt = r_fail_code;
        w_match_idx_nxt = r_match_idx;
        w_seq_ok_nxt    = r_seq_ok;
        w_seq_fail_nxt  = r_seq_fail;
        w_err_inc       = 1'b0;
        w_to_clr        = 1'b0;
        w_to_load       = 1'b0;
        w_to_dec        = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_hit) begin
                    w_state_nxt     = StCheck;
                    w_match_idx_nxt = 3'd1;
                    w_led_nxt       = i_code_in;
                    w_to_load       = 1'b1;
                end else if (i_code_valid && (i_code_in != '0)) begin
                    w_err_inc = 1'b1;
                end
            end
            StCheck: begin
                if (w_hit) begin
                    w_match_idx_nxt = r_match_idx + 3'd1;
                    w_led_nxt       = i_code_in;
                    if (r_match_idx + 3'd1 == LastIdx) begin
                        w_state_nxt  = StDoneOk;
                        w_seq_ok_nxt = 1'b1;
                        w_to_clr     = 1'b1;
                    end else begin
                        w_to_load = 1'b1;
                    end
                end else if (i_code_valid) begin
                    w_state_nxt     = StDoneFail;
                    w_seq_fail_nxt  = 1'b1;
                    w_fail_code_nxt = i_code_in;
                    w_err_inc       = 1'b1;
                    w_to_clr        = 1'b1;
                end else if (w_to_expire) begin
                    w_state_nxt     = StDoneFail;
                    w_seq_fail_nxt  = 1'b1;
                    w_fail_code_nxt = '0;
                    w_err_inc       = 1'b1;
                    w_to_clr        = 1'b1;
                end else begin
                    w_to_dec = 1'b1;
                end
            end
            StDoneOk, StDoneFail: begin
                if (i_rearm) begin
                    w_state_nxt     = StIdle;
                    w_seq_ok_nxt    = 1'b0;
                    w_seq_fail_nxt  = 1'b0;
                    w_match_idx_nxt = '0;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_led       <= '0;
            r_fail_code <= '0;
            r_match_idx <= '0;
            r_seq_ok    <= 1'b0;
            r_seq_fail  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_led       <= w_led_nxt;
            r_fail_code <= w_fail_code_nxt;
            r_match_idx <= w_match_idx_nxt;
            r_seq_ok    <= w_seq_ok_nxt;
            r_seq_fail  <= w_seq_fail_nxt;
        end
    end

    // Saturating error counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_count <= '0;
        end else if (w_err_inc && (r_err_count != {ERR_W{1'b1}})) begin
            r_err_count <= r_err_count + 1'b1;
        end
    end

    assign o_led       = r_led;
    assign o_busy      = (r_state == StCheck);
    assign o_seq_ok    = r_seq_ok;
    assign o_seq_fail  = r_seq_fail;
    assign o_fail_code = r_fail_code;
    assign o_match_idx = r_match_idx;
    assign o_err_count = r_err_count;

endmodule

// File: tb/tb_code_seq_checker.sv
// Directed bench: one checker at default timing, one with a short timeout and 2-bit error count.
module tb_code_seq_checker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] code_in = '0;
    logic       code_valid = 1'b0;
    logic       rearm = 1'b0;

    logic [7:0] a_led, a_fail_code, a_err;
    logic       a_busy, a_ok, a_fail;
    logic [2:0] a_idx;
    logic [7:0] b_led, b_fail_code;
    logic [1:0] b_err;
    logic       b_busy, b_ok, b_fail;
    logic [2:0] b_idx;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    code_seq_checker u_dut_a (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_code_in    (code_in),
        .i_code_valid (code_valid),
        .i_rearm      (rearm),
        .o_led        (a_led),
        .o_busy       (a_busy),
        .o_seq_ok     (a_ok),
        .o_seq_fail   (a_fail),
        .o_fail_code  (a_fail_code),
        .o_match_idx  (a_idx),
        .o_err_count  (a_err)
    );

    code_seq_checker #(
        .TO_CYCLES (20),
        .ERR_W     (2)
    ) u_dut_b (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_code_in    (code_in),
        .i_code_valid (code_valid),
        .i_rearm      (rearm),
        .o_led        (b_led),
        .o_busy       (b_busy),
        .o_seq_ok     (b_ok),
        .o_seq_fail   (b_fail),
        .o_fail_code  (b_fail_code),
        .o_match_idx  (b_idx),
        .o_err_count  (b_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send(input logic [7:0] c);
        code_in    = c;
        code_valid = 1'b1;
        tick();
        code_valid = 1'b0;
        code_in    = '0;
    endtask

    task automatic pulse_rearm();
        rearm = 1'b1;
        tick();
        rearm = 1'b0;
    endtask

    task automatic do_reset();
        code_valid = 1'b0;
        rearm      = 1'b0;
        rst_n      = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset state
        #3;
        check("rst_led", 32'(a_led), 32'h0);
        check("rst_busy", 32'(a_busy), 32'h0);
        check("rst_ok_fail", {30'd0, a_ok, a_fail}, 32'h0);
        check("rst_fail_code", 32'(a_fail_code), 32'h0);
        check("rst_idx", 32'(a_idx), 32'h0);
        check("rst_err", 32'(a_err), 32'h0);
        tick();
        rst_n = 1'b1;

        // Clean pass
        send(8'h10);
        check("clean_busy", 32'(a_busy), 32'h1);
        check("clean_idx1", 32'(a_idx), 32'h1);
        send(8'h92);
        send(8'h53);
        send(8'hEE);
        check("clean_ok_early", 32'(a_ok), 32'h0);
        send(8'h77);
        check("clean_ok", 32'(a_ok), 32'h1);
        check("clean_idx5", 32'(a_idx), 32'h5);
        check("clean_led", 32'(a_led), 32'h77);
        check("clean_err", 32'(a_err), 32'h0);
        check("clean_busy_off", 32'(a_busy), 32'h0);
        send(8'hAA);
        check("done_ignores_ok", 32'(a_ok), 32'h1);
        check("done_ignores_err", 32'(a_err), 32'h0);
        pulse_rearm();
        check("rearm_ok_clr", 32'(a_ok), 32'h0);
        check("rearm_idx_clr", 32'(a_idx), 32'h0);
        check("rearm_led_hold", 32'(a_led), 32'h77);

        // Gapped pass with filler
        send(8'h00);
        send(8'h00);
        check("filler_err", 32'(a_err), 32'h0);
        check("filler_idle", 32'(a_busy), 32'h0);
        send(8'h10);
        idle(10);
        send(8'h92);
        idle(10);
        send(8'h53);
        idle(10);
        send(8'hEE);
        idle(10);
        send(8'h77);
        check("gap_ok_a", 32'(a_ok), 32'h1);
        check("gap_ok_b", 32'(b_ok), 32'h1);
        check("gap_err_a", 32'(a_err), 32'h0);
        check("gap_err_b", 32'(b_err), 32'h0);
        pulse_rearm();

        // Mismatch, then rearm racing a valid code
        send(8'h10);
        send(8'h92);
        send(8'h55);
        check("mm_fail", 32'(a_fail), 32'h1);
        check("mm_fail_code", 32'(a_fail_code), 32'h55);
        check("mm_idx", 32'(a_idx), 32'h2);
        check("mm_err", 32'(a_err), 32'h1);
        send(8'h10);
        check("mm_ignore_err", 32'(a_err), 32'h1);
        check("mm_ignore_busy", 32'(a_busy), 32'h0);
        rearm = 1'b1;
        send(8'h10);
        rearm = 1'b0;
        check("race_idx", 32'(a_idx), 32'h0);
        check("race_busy", 32'(a_busy), 32'h0);
        check("race_fail_clr", 32'(a_fail), 32'h0);
        check("race_fail_code_hold", 32'(a_fail_code), 32'h55);

        // Timeout (B: 20 cycles)
        do_reset();
        send(8'h10);
        idle(19);
        check("to_not_yet", 32'(b_fail), 32'h0);
        check("to_busy", 32'(b_busy), 32'h1);
        idle(1);
        check("to_fail", 32'(b_fail), 32'h1);
        check("to_fail_code", 32'(b_fail_code), 32'h0);
        check("to_err", 32'(b_err), 32'h1);
        check("to_a_still_busy", 32'(a_busy), 32'h1);

        // Valid code on the expiry cycle wins; counter restarts after the match
        do_reset();
        send(8'h10);
        idle(19);
        send(8'h92);
        check("to_race_busy", 32'(b_busy), 32'h1);
        check("to_race_idx", 32'(b_idx), 32'h2);
        idle(19);
        check("to_reload_not_yet", 32'(b_fail), 32'h0);
        idle(1);
        check("to_reload_fail", 32'(b_fail), 32'h1);

        // Rearm in IDLE is a no-op; error saturation
        do_reset();
        pulse_rearm();
        check("idle_rearm_busy", 32'(b_busy), 32'h0);
        repeat (3) send(8'hAA);
        check("sat_b3", 32'(b_err), 32'h3);
        repeat (2) send(8'hAA);
        check("sat_b_hold", 32'(b_err), 32'h3);
        check("sat_a5", 32'(a_err), 32'h5);
        send(8'h10);
        send(8'h92);
        send(8'h53);
        send(8'hEE);
        send(8'h77);
        check("sat_pass_b", 32'(b_ok), 32'h1);
        check("sat_pass_a", 32'(a_ok), 32'h1);

        // Async reset mid-CHECK
        do_reset();
        send(8'h10);
        send(8'h92);
        send(8'h53);
        check("ar_idx3", 32'(a_idx), 32'h3);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_idx", 32'(a_idx), 32'h0);
        check("ar_led", 32'(a_led), 32'h0);
        check("ar_busy", 32'(a_busy), 32'h0);
        check("ar_flags", {30'd0, a_ok, a_fail}, 32'h0);
        #2;
        rst_n = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
